// File: rtl/q15_dot_accum.sv
// Q15 (16.48 fixed point) dot product engine: one product term per cycle,
// sticky NaN/inf tracking and saturation of the wide accumulator on completion.
module q15_dot_accum #(
  parameter int NTERM = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [64*NTERM-1:0]   a_vec,
  input  logic [64*NTERM-1:0]   b_vec,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [63:0]           out_res,
  output logic [1:0]            o_dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; valid never waits on ready, and ready depends only on state.
  localparam logic [63:0] Q_NAN  = 64'h8000_0000_0000_0000;
  localparam logic [63:0] Q_PINF = 64'h7FFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] Q_NINF = 64'h8000_0000_0000_0001;
  localparam logic signed [66:0] ACC_MAX = 67'sh0_7FFF_FFFF_FFFF_FFFE;
  localparam logic signed [66:0] ACC_MIN = 67'sh7_8000_0000_0000_0002;
  localparam logic [1:0] LAST = 2'(NTERM - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MAC  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                r_state, w_state_nxt;
  logic [64*NTERM-1:0]   r_a, r_b;
  logic [1:0]            r_cnt;
  logic signed [66:0]    r_acc;
  logic                  r_nan, r_pinf, r_ninf;
  logic [63:0]           r_res;

  logic                  w_accept, w_last;
  logic [7:0]            w_base;
  logic [63:0]           w_a, w_b, w_prod, w_res;
  logic signed [127:0]   w_a_ext, w_b_ext, w_full;
  logic                  w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_a_zero, w_b_zero;
  logic                  w_neg, w_ovf;
  logic                  w_t_nan, w_t_pinf, w_t_ninf, w_t_fin;
  logic                  w_nan_nxt, w_pinf_nxt, w_ninf_nxt;
  logic signed [66:0]    w_acc_nxt;

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_state_nxt = S_MAC;
      end
      S_MAC:  if (r_cnt == LAST) w_state_nxt = S_DONE;
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_accept    = in_valid & in_ready;
  assign w_last      = (r_state == S_MAC) && (r_cnt == LAST);
  assign o_dbg_state = r_state;
  assign out_res     = r_res;

  assign w_base   = {r_cnt, 6'd0};
  assign w_a      = r_a[w_base +: 64];
  assign w_b      = r_b[w_base +: 64];
  assign w_a_nan  = (w_a == Q_NAN);
  assign w_b_nan  = (w_b == Q_NAN);
  assign w_a_inf  = (w_a == Q_PINF) || (w_a == Q_NINF);
  assign w_b_inf  = (w_b == Q_PINF) || (w_b == Q_NINF);
  assign w_a_zero = (w_a == 64'd0);
  assign w_b_zero = (w_b == 64'd0);
  assign w_neg    = w_a[63] ^ w_b[63];

  // Full-width product; the Q15 result is the window [111:48] and anything
  // above bit 111 that is not pure sign extension is an overflow.
  assign w_a_ext = {{64{w_a[63]}}, w_a};
  assign w_b_ext = {{64{w_b[63]}}, w_b};
  assign w_full  = w_a_ext * w_b_ext;
  assign w_ovf   = ~((&w_full[127:111]) | ~(|w_full[127:111]));
  assign w_prod  = w_full[111:48];

  always_comb begin
    w_t_nan  = 1'b0;
    w_t_pinf = 1'b0;
    w_t_ninf = 1'b0;
    w_t_fin  = 1'b0;
    if (w_a_nan || w_b_nan) begin
      w_t_nan = 1'b1;
    end else if (w_a_inf || w_b_inf) begin
      if ((w_a_inf && w_b_zero) || (w_b_inf && w_a_zero)) w_t_nan = 1'b1;
      else if (w_neg)                                      w_t_ninf = 1'b1;
      else                                                 w_t_pinf = 1'b1;
    end else if (w_ovf) begin
      w_t_ninf = w_neg;
      w_t_pinf = ~w_neg;
    end else begin
      w_t_fin = 1'b1;
    end
  end

  assign w_acc_nxt  = w_t_fin ? (r_acc + $signed({{3{w_prod[63]}}, w_prod})) : r_acc;
  assign w_pinf_nxt = r_pinf | w_t_pinf;
  assign w_ninf_nxt = r_ninf | w_t_ninf;
  assign w_nan_nxt  = r_nan | w_t_nan | (w_pinf_nxt & w_ninf_nxt);

  always_comb begin
    w_res = w_acc_nxt[63:0];
    if (w_nan_nxt)                w_res = Q_NAN;
    else if (w_pinf_nxt)          w_res = Q_PINF;
    else if (w_ninf_nxt)          w_res = Q_NINF;
    else if (w_acc_nxt > ACC_MAX) w_res = Q_PINF;
    else if (w_acc_nxt < ACC_MIN) w_res = Q_NINF;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_a    <= '0;
      r_b    <= '0;
      r_cnt  <= 2'd0;
      r_acc  <= '0;
      r_nan  <= 1'b0;
      r_pinf <= 1'b0;
      r_ninf <= 1'b0;
      r_res  <= '0;
    end else if (w_accept) begin
      r_a    <= a_vec;
      r_b    <= b_vec;
      r_cnt  <= 2'd0;
      r_acc  <= '0;
      r_nan  <= 1'b0;
      r_pinf <= 1'b0;
      r_ninf <= 1'b0;
    end else if (r_state == S_MAC) begin
      r_acc  <= w_acc_nxt;
      r_nan  <= w_nan_nxt;
      r_pinf <= w_pinf_nxt;
      r_ninf <= w_ninf_nxt;
      r_cnt  <= w_last ? 2'd0 : r_cnt + 2'd1;
      if (w_last) r_res <= w_res;
    end
  end

endmodule

// File: tb/tb_q15_dot_accum.sv
// Bench for q15_dot_accum: directed special-value and boundary cases plus
// random transactions, checked against an arithmetic reference model.
module tb_q15_dot_accum;

  localparam int NT = 3;
  localparam int W  = 64;
  localparam logic [63:0] Q_NAN   = 64'h8000_0000_0000_0000;
  localparam logic [63:0] Q_PINF  = 64'h7FFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] Q_NINF  = 64'h8000_0000_0000_0001;
  localparam logic [63:0] ONE     = 64'h0001_0000_0000_0000;
  localparam logic [63:0] NEG_ONE = 64'hFFFF_0000_0000_0000;
  localparam logic [63:0] EPS     = 64'h0000_0000_0000_0001;
  localparam logic [63:0] NEPS    = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] BIG     = 64'h4000_0000_0000_0000;
  localparam logic [63:0] NBIG    = 64'hC000_0000_0000_0000;
  localparam logic [63:0] F181    = 64'h00B5_0000_0000_0000;
  localparam logic [63:0] N181    = 64'hFF4B_0000_0000_0000;

  logic             clk = 1'b0;
  logic             reset, in_valid, out_ready;
  logic             in_ready, out_valid;
  logic [64*NT-1:0] a_vec, b_vec;
  logic [63:0]      out_res;
  logic [1:0]       dbg_state;

  int               checks = 0;
  int               errors = 0;
  logic [W-1:0]     exp_q[$];

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  q15_dot_accum #(.NTERM(NT)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a_vec(a_vec), .b_vec(b_vec), .out_valid(out_valid), .out_ready(out_ready),
    .out_res(out_res), .o_dbg_state(dbg_state)
  );

  // reference model: plain integer arithmetic on the Q15 values
  function automatic logic [63:0] ref_dot(input logic [64*NT-1:0] av, input logic [64*NT-1:0] bv);
    logic signed [63:0]  xs, ys;
    logic signed [127:0] x, y, p, sum, max64, min64, hi, lo;
    bit nan, pinf, ninf, xn, yn, xi, yi, neg;
    max64 = 128'sh7FFF_FFFF_FFFF_FFFF;
    min64 = -max64 - 128'sd1;
    hi    = max64 - 128'sd1;
    lo    = -hi;
    sum = '0; nan = 0; pinf = 0; ninf = 0;
    for (int i = 0; i < NT; i++) begin
      xs = av[64*i +: 64];
      ys = bv[64*i +: 64];
      xn = (xs == Q_NAN);
      yn = (ys == Q_NAN);
      xi = (xs == Q_PINF) || (xs == Q_NINF);
      yi = (ys == Q_PINF) || (ys == Q_NINF);
      neg = (xs < 0) != (ys < 0);
      if (xn || yn) nan = 1;
      else if (xi || yi) begin
        if ((xi && ys == 0) || (yi && xs == 0)) nan = 1;
        else if (neg) ninf = 1;
        else pinf = 1;
      end else begin
        x = {{64{xs[63]}}, xs};
        y = {{64{ys[63]}}, ys};
        p = (x * y) >>> 48;
        if (p > max64 || p < min64) begin
          if (neg) ninf = 1;
          else pinf = 1;
        end else sum = sum + p;
      end
    end
    if (nan || (pinf && ninf)) return Q_NAN;
    if (pinf) return Q_PINF;
    if (ninf) return Q_NINF;
    if (sum > hi) return Q_PINF;
    if (sum < lo) return Q_NINF;
    return sum[63:0];
  endfunction

  function automatic logic [64*NT-1:0] pack3(input logic [63:0] x0, input logic [63:0] x1, input logic [63:0] x2);
    return {x2, x1, x0};
  endfunction

  function automatic logic [63:0] rnd_q();
    logic signed [63:0] v;
    int r;
    r = $urandom_range(0, 19);
    case (r)
      0: return Q_NAN;
      1: return Q_PINF;
      2: return Q_NINF;
      3: return 64'd0;
      4: return ONE;
      5: return {$urandom, $urandom};
      default: begin
        v = {$urandom, $urandom};
        v = v >>> $urandom_range(14, 40);
        return v;
      end
    endcase
  endfunction

  // scoreboard comparison
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // driver: one full transaction with a DONE stall of 'hold' cycles
  task automatic run_txn(input string tag, input logic [64*NT-1:0] av, input logic [64*NT-1:0] bv, input int hold);
    int cyc;
    logic [63:0] exp;
    cyc = 0;
    while (!in_ready && cyc < 20) begin tick(); cyc++; end
    check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    a_vec = av;
    b_vec = bv;
    in_valid = 1'b1;
    exp_q.push_back(ref_dot(av, bv));
    tick();
    in_valid = 1'b0;
    a_vec = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    b_vec = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    cyc = 0;
    while (!out_valid && cyc < 20) begin tick(); cyc++; end
    check({tag, "_latency"}, 64'(cyc), 64'(NT));
    exp = exp_q.pop_front();
    check({tag, "_res"}, out_res, exp);
    check({tag, "_busy"}, 64'(in_ready), 64'd0);
    for (int h = 0; h < hold; h++) begin
      tick();
      check({tag, "_hold_valid"}, 64'(out_valid), 64'd1);
      check({tag, "_hold_res"}, out_res, exp);
      check({tag, "_hold_busy"}, 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_post_valid"}, 64'(out_valid), 64'd0);
    check({tag, "_post_ready"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a_vec = '0; b_vec = '0;
    tick(); tick();
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_res", out_res, 64'd0);
    reset = 1'b0;
    tick();

    run_txn("basic32", pack3(ONE, 64'h0002_0000_0000_0000, 64'h0003_0000_0000_0000),
            pack3(64'h0004_0000_0000_0000, 64'h0005_0000_0000_0000, 64'h0006_0000_0000_0000), 5);
    check("basic32_const", out_res, 64'h0020_0000_0000_0000);
    run_txn("nan_op", pack3(Q_NAN, ONE, ONE), pack3(ONE, ONE, ONE), 0);
    run_txn("pinf_ninf", pack3(Q_PINF, Q_NINF, 64'd0), pack3(ONE, ONE, 64'd0), 1);
    run_txn("inf_zero", pack3(Q_PINF, 64'd0, 64'd0), pack3(64'd0, 64'd0, 64'd0), 0);
    run_txn("inf_negone", pack3(Q_PINF, 64'd0, 64'd0), pack3(NEG_ONE, 64'd0, 64'd0), 0);
    run_txn("big_sq", pack3(BIG, 64'd0, 64'd0), pack3(BIG, 64'd0, 64'd0), 0);
    run_txn("big_sq_neg", pack3(NBIG, 64'd0, 64'd0), pack3(BIG, 64'd0, 64'd0), 0);
    run_txn("sum_pos", pack3(F181, F181, 64'd0), pack3(F181, F181, 64'd0), 2);
    run_txn("sum_neg", pack3(N181, N181, 64'd0), pack3(F181, F181, 64'd0), 0);
    run_txn("ovf_both", pack3(BIG, BIG, 64'd0), pack3(BIG, NBIG, 64'd0), 0);
    run_txn("edge_max", pack3(64'h7FFF_FFFF_FFFF_FFFE, 64'd0, 64'd0), pack3(ONE, 64'd0, 64'd0), 0);
    run_txn("edge_max1", pack3(64'h7FFF_FFFF_FFFF_FFFE, ONE, 64'd0), pack3(ONE, EPS, 64'd0), 0);
    run_txn("edge_min", pack3(64'h8000_0000_0000_0002, 64'd0, 64'd0), pack3(ONE, 64'd0, 64'd0), 0);
    run_txn("edge_min1", pack3(64'h8000_0000_0000_0002, ONE, 64'd0), pack3(ONE, NEPS, 64'd0), 0);

    // reset on the second MAC cycle must drop the transaction entirely
    a_vec = pack3(ONE, ONE, ONE);
    b_vec = pack3(ONE, ONE, ONE);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_rst_in_ready", 64'(in_ready), 64'd1);
    check("mid_rst_out_valid", 64'(out_valid), 64'd0);
    check("mid_rst_out_res", out_res, 64'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("mid_rst_quiet", 64'(out_valid), 64'd0);
    end
    run_txn("after_rst", pack3(ONE, 64'h0002_0000_0000_0000, 64'h0003_0000_0000_0000),
            pack3(ONE, ONE, ONE), 0);
    check("after_rst_const", out_res, 64'h0006_0000_0000_0000);

    for (int t = 0; t < 40; t++) begin
      run_txn("rand", pack3(rnd_q(), rnd_q(), rnd_q()), pack3(rnd_q(), rnd_q(), rnd_q()),
              $urandom_range(0, 3));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/q15_dot_accum.md
Q15_DOT_ACCUM -- requirements
Module: q15_dot_accum

Interface
REQ-001 SHALL provide parameter NTERM, default 3, meaning number of product terms per dot product (legal 1..4).
REQ-002 SHALL provide port clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL provide port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL provide port in_valid  input  1  operand vectors present.
REQ-005 SHALL provide port in_ready  output  1  block can accept operands.
REQ-006 SHALL provide port a_vec  input  64*NTERM  signed Q15 terms a[i], where term i occupies bits [64*i+63:64*i].
REQ-007 SHALL provide port b_vec  input  64*NTERM  signed Q15 terms b[i], packed the same way as a_vec.
REQ-008 SHALL provide port out_valid  output  1  result present.
REQ-009 SHALL provide port out_ready  input  1  consumer accepts result.
REQ-010 SHALL provide port out_res  output  64  Q15 dot product sum(a[i]*b[i]).

Function
REQ-011 SHALL treat Q15 values as 64-bit two's complement: 16 integer bits including sign, 48 fraction bits (1.0 = 0x0001_0000_0000_0000).
REQ-012 SHALL use the special encodings NaN = 0x8000_0000_0000_0000, +inf = 0x7FFF_FFFF_FFFF_FFFF and -inf = 0x8000_0000_0000_0001; every other code is finite.
REQ-013 SHALL implement the FSM states IDLE, MAC and DONE, where IDLE->MAC on in_valid&in_ready, MAC->DONE after the last term, and DONE->IDLE on out_valid&out_ready.
REQ-014 SHALL drive in_ready=1 only in IDLE and out_valid=1 only in DONE.
REQ-015 SHALL capture a_vec and b_vec into internal registers on acceptance; later input changes SHALL have no effect.
REQ-016 SHALL, in MAC, process one term per cycle using a term counter 0..NTERM-1, so out_valid rises exactly NTERM cycles after the accepting edge.
REQ-017 SHALL form each finite product as the full 128-bit signed a*b, take bits [111:48] (arithmetic shift right by 48), and detect overflow when bits [127:111] are not all equal.
REQ-018 SHALL apply these per-term special rules: any NaN operand -> NaN; inf*0 -> NaN; inf*nonzero or product overflow -> inf with sign = sign(a) xor sign(b).
REQ-019 SHALL accumulate finite products in a 67-bit signed accumulator, cleared on acceptance, with no intermediate saturation.
REQ-020 SHALL keep sticky flags nan_s, pinf_s and ninf_s, cleared on acceptance and set by the per-term results.
REQ-021 SHALL set nan_s when pinf_s and ninf_s are both set.
REQ-022 SHALL resolve the result on the MAC->DONE transition with priority nan_s -> NaN, pinf_s -> +inf, ninf_s -> -inf.
REQ-023 SHALL, when no sticky flag is set, saturate the accumulator: >0x7FFF_FFFF_FFFF_FFFE -> +inf; <0x8000_0000_0000_0002 -> -inf; otherwise the low 64 bits.
REQ-024 SHALL hold out_res stable in DONE while out_ready=0, and SHALL update out_res only on the MAC->DONE transition.
REQ-025 SHALL NOT accept new operands in the cycle a result is consumed; in_ready rises the cycle after DONE->IDLE.
REQ-026 SHALL ignore in_valid outside IDLE and out_ready outside DONE.

Reset
REQ-027 SHALL on reset force the state to IDLE and drive in_ready=1, out_valid=0 and out_res=0.
REQ-028 SHALL on reset clear the term counter, accumulator and all sticky flags.
REQ-029 SHALL abort any in-progress MAC or DONE on reset with no output produced, reset taking priority over every handshake in the same cycle.

Verification
REQ-030 SHALL be verified with: a=(1.0,2.0,3.0), b=(4.0,5.0,6.0), NTERM=3 -> out_valid 3 cycles after accept, out_res=0x0020_0000_0000_0000 (32.0).
REQ-031 SHALL be verified with: a=(NaN,1.0,1.0), b=(1.0,1.0,1.0) -> out_res=0x8000_0000_0000_0000.
REQ-032 SHALL be verified with: a=(+inf,-inf,0), b=(1.0,1.0,0) -> out_res=NaN; a=(+inf,0,0), b=(0,..) -> NaN.
REQ-033 SHALL be verified with: a=(0x4000_0000_0000_0000,...) squared, and with sums exceeding 32767.0 -> out_res=+inf; mirrored negative operands -> -inf.
REQ-034 SHALL be verified with: out_ready held 0 for 5 cycles in DONE -> out_valid=1 and out_res unchanged throughout, in_ready=0; out_ready=1 -> in_ready=1 next cycle.
REQ-035 SHALL be verified with: reset asserted on the 2nd MAC cycle -> next cycle in_ready=1, out_valid=0 and out_res=0; next transaction result is correct with no residue.
